// File: rtl/mux8_arbiter.sv
// Round-robin arbiter/sequencer for an 8-way shared resource: grants one requester,
// drives the mux select, pulses start, and releases on resp or timeout.
module mux8_arbiter #(
  parameter int unsigned timeout = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req,
  input  logic       resp,
  output logic [2:0] sel,
  output logic [7:0] gnt,
  output logic       start,
  output logic [7:0] done,
  output logic       err,
  output logic       busy
);

  localparam int unsigned CntW = (timeout == 0) ? 1 : $clog2(timeout + 1);
  localparam logic [CntW-1:0] CntMax  = CntW'(timeout);
  localparam logic [CntW-1:0] CntLast = CntW'((timeout == 0) ? 0 : timeout - 1);

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  state_e          r_state;
  logic [2:0]      r_ptr;
  logic [CntW-1:0] r_cnt;
  logic [2:0]      r_sel;
  logic [7:0]      r_gnt;
  logic            r_start;
  logic            r_err;

  logic [15:0] w_req2;
  logic [7:0]  w_rot;
  logic [2:0]  w_off;
  logic [2:0]  w_win;
  logic [7:0]  w_win_oh;
  logic        w_expire;

  // Rotate req so bit 0 is the requester at ptr; the lowest set bit is then the winner.
  assign w_req2 = {req, req};
  assign w_rot  = w_req2[r_ptr +: 8];

  always_comb begin
    w_off = 3'd0;
    for (int k = 7; k >= 0; k--) begin
      if (w_rot[k]) w_off = 3'(k);
    end
  end

  assign w_win    = r_ptr + w_off;
  assign w_win_oh = 8'b1 << w_win;
  assign w_expire = (timeout != 0) && (r_cnt == CntLast);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= StIdle;
      r_ptr   <= 3'd0;
      r_cnt   <= '0;
      r_sel   <= 3'd0;
      r_gnt   <= 8'd0;
      r_start <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_start <= 1'b0;
      r_err   <= 1'b0;
      case (r_state)
        StIdle: begin
          if (|req) begin
            r_state <= StBusy;
            r_gnt   <= w_win_oh;
            r_sel   <= w_win;
            r_start <= 1'b1;
            r_cnt   <= '0;
          end else begin
            r_gnt <= 8'd0;
          end
        end
        StBusy: begin
          // resp has priority over a coincident timeout
          if (resp) begin
            r_state <= StIdle;
            r_gnt   <= 8'd0;
            r_ptr   <= r_sel + 3'd1;
          end else if (w_expire) begin
            r_state <= StIdle;
            r_gnt   <= 8'd0;
            r_ptr   <= r_sel + 3'd1;
            r_err   <= 1'b1;
          end else if (r_cnt != CntMax) begin
            r_cnt <= r_cnt + CntW'(1);
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign sel   = r_sel;
  assign gnt   = r_gnt;
  assign start = r_start;
  assign err   = r_err;
  assign busy  = (r_state == StBusy);
  assign done  = r_gnt & {8{resp}};

  a_gnt_onehot : assert property (@(posedge clk) disable iff (rst) $onehot0(r_gnt));
  a_start_busy : assert property (@(posedge clk) disable iff (rst) r_start |-> busy);
  a_err_idle   : assert property (@(posedge clk) disable iff (rst) r_err |-> !busy);
  a_gnt_sel    : assert property (@(posedge clk) disable iff (rst) busy |-> (r_gnt == w_sel_oh()));

  function automatic logic [7:0] w_sel_oh();
    return 8'b1 << r_sel;
  endfunction

endmodule

// File: tb/tb_mux8_arbiter.sv
// Self-checking bench for mux8_arbiter: directed scenarios plus randomized traffic
// compared against a behavioural round-robin model.
module tb_mux8_arbiter;

  localparam int TO = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] req;
  logic       resp;
  logic [2:0] sel;
  logic [7:0] gnt;
  logic       start;
  logic [7:0] done;
  logic       err;
  logic       busy;

  int vec  = 0;
  int miss = 0;

  mux8_arbiter #(.timeout(TO)) dut (
    .clk   (clk),
    .rst   (rst),
    .req   (req),
    .resp  (resp),
    .sel   (sel),
    .gnt   (gnt),
    .start (start),
    .done  (done),
    .err   (err),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  // Behavioural model: round-robin winner by scanning from the pointer.
  function automatic int winner(input logic [2:0] p, input logic [7:0] r);
    for (int k = 0; k < 8; k++) begin
      if (r[(int'(p) + k) % 8]) return (int'(p) + k) % 8;
    end
    return 0;
  endfunction

  logic       m_busy;
  logic [2:0] m_ptr, m_w, m_sel;
  logic [7:0] m_gnt;
  logic       m_start, m_err;
  int         m_elapsed;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy <= 1'b0; m_ptr <= 3'd0; m_w <= 3'd0; m_sel <= 3'd0;
      m_gnt <= 8'd0; m_start <= 1'b0; m_err <= 1'b0; m_elapsed <= 0;
    end else if (!m_busy) begin
      m_start <= 1'b0;
      m_err   <= 1'b0;
      if (req != 8'd0) begin
        m_busy    <= 1'b1;
        m_w       <= 3'(winner(m_ptr, req));
        m_sel     <= 3'(winner(m_ptr, req));
        m_gnt     <= 8'(1) << winner(m_ptr, req);
        m_start   <= 1'b1;
        m_elapsed <= 1;
      end
    end else begin
      m_start <= 1'b0;
      m_err   <= 1'b0;
      if (resp) begin
        m_busy <= 1'b0; m_gnt <= 8'd0; m_ptr <= m_w + 3'd1;
      end else if (m_elapsed == TO) begin
        m_busy <= 1'b0; m_gnt <= 8'd0; m_ptr <= m_w + 3'd1; m_err <= 1'b1;
      end else begin
        m_elapsed <= m_elapsed + 1;
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; req = 8'd0; resp = 1'b0;
    #3;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req = 8'd0; resp = 1'b0;
    #2;
    vec++; if (gnt !== 8'd0) begin miss++; $display("FAIL reset_gnt: got %h want 00", gnt); end
    vec++; if (sel !== 3'd0) begin miss++; $display("FAIL reset_sel: got %0d want 0", sel); end
    vec++; if (start !== 1'b0 || err !== 1'b0 || busy !== 1'b0) begin
      miss++; $display("FAIL reset_ctl: start=%b err=%b busy=%b want 000", start, err, busy);
    end
    vec++; if (done !== 8'd0) begin miss++; $display("FAIL reset_done: got %h want 00", done); end
    cyc();
    rst = 1'b0;
  endtask

  task automatic test_single();
    do_reset();
    req = 8'h08;
    cyc();
    vec++; if (gnt !== 8'h08 || sel !== 3'd3 || start !== 1'b1) begin
      miss++; $display("FAIL single_grant: gnt=%h sel=%0d start=%b want 08 3 1", gnt, sel, start);
    end
    req = 8'h00;
    for (int k = 1; k < 4; k++) begin
      cyc();
      vec++; if (gnt !== 8'h08 || start !== 1'b0 || busy !== 1'b1) begin
        miss++; $display("FAIL single_hold: gnt=%h start=%b busy=%b want 08 0 1", gnt, start, busy);
      end
    end
    cyc();
    resp = 1'b1;
    #1;
    vec++; if (done !== 8'h08) begin miss++; $display("FAIL single_done: got %h want 08", done); end
    cyc();
    resp = 1'b0;
    vec++; if (gnt !== 8'h00 || busy !== 1'b0) begin
      miss++; $display("FAIL single_release: gnt=%h busy=%b want 00 0", gnt, busy);
    end
    req = 8'h11;
    cyc();
    vec++; if (gnt !== 8'h10) begin miss++; $display("FAIL single_ptr4: got %h want 10", gnt); end
    resp = 1'b1; cyc(); resp = 1'b0; req = 8'h00;
  endtask

  task automatic test_rotation();
    do_reset();
    req = 8'hFF;
    cyc();
    for (int k = 0; k < 9; k++) begin
      vec++; if (sel !== 3'(k % 8) || start !== 1'b1) begin
        miss++; $display("FAIL rotation_sel%0d: sel=%0d start=%b want %0d 1", k, sel, start, k % 8);
      end
      resp = 1'b1;
      cyc();
      resp = 1'b0;
      cyc();
    end
    req = 8'h00;
    cyc();
  endtask

  task automatic test_wrap();
    do_reset();
    req = 8'h01; cyc(); resp = 1'b1; cyc(); resp = 1'b0;
    req = 8'h81;
    cyc();
    vec++; if (sel !== 3'd7) begin miss++; $display("FAIL wrap_81_first: sel=%0d want 7", sel); end
    resp = 1'b1; cyc(); resp = 1'b0;
    cyc();
    vec++; if (sel !== 3'd0) begin miss++; $display("FAIL wrap_81_second: sel=%0d want 0", sel); end
    resp = 1'b1; cyc(); resp = 1'b0; req = 8'h00;
    do_reset();
    req = 8'h40; cyc(); resp = 1'b1; cyc(); resp = 1'b0;
    req = 8'h03;
    cyc();
    vec++; if (sel !== 3'd0) begin miss++; $display("FAIL wrap_03_first: sel=%0d want 0", sel); end
    resp = 1'b1; cyc(); resp = 1'b0;
    cyc();
    vec++; if (sel !== 3'd1) begin miss++; $display("FAIL wrap_03_second: sel=%0d want 1", sel); end
    resp = 1'b1; cyc(); resp = 1'b0; req = 8'h00;
  endtask

  task automatic test_timeout();
    do_reset();
    req = 8'h20;
    cyc();
    req = 8'h00;
    for (int k = 1; k < TO; k++) begin
      cyc();
      vec++; if (err !== 1'b0 || gnt !== 8'h20) begin
        miss++; $display("FAIL timeout_wait%0d: err=%b gnt=%h want 0 20", k, err, gnt);
      end
    end
    cyc();
    vec++; if (err !== 1'b1 || gnt !== 8'h00 || busy !== 1'b0) begin
      miss++; $display("FAIL timeout_err: err=%b gnt=%h busy=%b want 1 00 0", err, gnt, busy);
    end
    cyc();
    vec++; if (err !== 1'b0) begin miss++; $display("FAIL timeout_pulse: err=%b want 0", err); end
    req = 8'h60;
    cyc();
    vec++; if (sel !== 3'd6) begin miss++; $display("FAIL timeout_ptr6: sel=%0d want 6", sel); end
    resp = 1'b1; cyc(); resp = 1'b0;
    req = 8'h20;
    cyc();
    req = 8'h00;
    for (int k = 1; k < TO - 1; k++) cyc();
    cyc();
    resp = 1'b1;
    #1;
    vec++; if (done !== 8'h20) begin miss++; $display("FAIL timeout_race_done: got %h want 20", done); end
    cyc();
    resp = 1'b0;
    vec++; if (err !== 1'b0 || gnt !== 8'h00) begin
      miss++; $display("FAIL timeout_race_err: err=%b gnt=%h want 0 00", err, gnt);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    req = 8'h10;
    cyc(); cyc(); cyc();
    #2;
    rst = 1'b1;
    #1;
    vec++; if (gnt !== 8'h00 || sel !== 3'd0 || busy !== 1'b0 || start !== 1'b0) begin
      miss++; $display("FAIL async_clear: gnt=%h sel=%0d busy=%b start=%b want 00 0 0 0",
                       gnt, sel, busy, start);
    end
    req = 8'h11;
    #2;
    rst = 1'b0;
    cyc();
    vec++; if (gnt !== 8'h01 || sel !== 3'd0) begin
      miss++; $display("FAIL async_first_grant: gnt=%h sel=%0d want 01 0", gnt, sel);
    end
    resp = 1'b1; cyc(); resp = 1'b0; req = 8'h00;
  endtask

  task automatic test_spurious();
    do_reset();
    resp = 1'b1;
    #1;
    vec++; if (done !== 8'h00) begin miss++; $display("FAIL spurious_done: got %h want 00", done); end
    cyc();
    resp = 1'b0;
    vec++; if (busy !== 1'b0 || gnt !== 8'h00) begin
      miss++; $display("FAIL spurious_state: busy=%b gnt=%h want 0 00", busy, gnt);
    end
    req = 8'h04;
    cyc();
    req = 8'h00;
    for (int k = 0; k < 3; k++) begin
      cyc();
      vec++; if (gnt !== 8'h04 || busy !== 1'b1) begin
        miss++; $display("FAIL dropped_hold: gnt=%h busy=%b want 04 1", gnt, busy);
      end
    end
    resp = 1'b1;
    #1;
    vec++; if (done !== 8'h04) begin miss++; $display("FAIL dropped_done: got %h want 04", done); end
    cyc();
    resp = 1'b0;
  endtask

  task automatic test_random();
    int r;
    do_reset();
    cyc();
    for (int i = 0; i < 1500; i++) begin
      r = int'($urandom_range(0, 3));
      if (r == 0)      req = 8'h00;
      else if (r == 1) req = 8'(1) << $urandom_range(0, 7);
      else             req = 8'($urandom);
      resp = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 299) == 0) rst = 1'b1;
      #1;
      vec++; if (gnt !== m_gnt || sel !== m_sel) begin
        miss++; $display("FAIL rand_gnt@%0d: gnt=%h sel=%0d want %h %0d", i, gnt, sel, m_gnt, m_sel);
      end
      vec++; if (start !== m_start || err !== m_err || busy !== m_busy) begin
        miss++; $display("FAIL rand_ctl@%0d: start=%b err=%b busy=%b want %b %b %b",
                         i, start, err, busy, m_start, m_err, m_busy);
      end
      vec++; if (done !== (resp ? m_gnt : 8'h00)) begin
        miss++; $display("FAIL rand_done@%0d: got %h want %h", i, done, resp ? m_gnt : 8'h00);
      end
      rst = 1'b0;
      cyc();
    end
    req = 8'h00; resp = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, want finish before 500000");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; req = 8'd0; resp = 1'b0;
    test_reset();
    test_single();
    test_rotation();
    test_wrap();
    test_timeout();
    test_async_reset();
    test_spurious();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule

// File: doc/mux8_arbiter.md
# mux8_arbiter

Round-robin arbiter and sequencer for an 8-input shared datapath resource, such as a shared memory port or result bus, whose source is chosen by an 8:1 select mux. It accepts requests from up to eight requesters and grants one requester at a time. It drives the 3-bit mux select, issues a start pulse to the resource and holds the grant until the resource responds or a timeout expires. It then rotates priority so that no requester starves.

## Interface
Parameters:
- timeout, 255: maximum number of BUSY cycles to wait for `resp` before aborting. 0 disables the timeout. The counter width is $clog2(timeout+1), with a minimum of 1.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  reset; asynchronous and active-high.
- req  in  8  request vector; bit i set means requester i wants the resource. Level-sensitive.
- resp  in  1  single-cycle pulse from the resource marking completion of the current transaction.
- sel  out  3  registered select for the 8:1 datapath mux; index of the granted requester.
- gnt  out  8  registered one-hot grant; all zero when idle.
- start  out  1  one-cycle pulse to the resource on the first cycle of each grant.
- done  out  8  one-hot completion pulse, combinational: done[i] = resp & gnt[i].
- err  out  1  one-cycle registered pulse when a transaction is aborted by timeout.
- busy  out  1  high while in the BUSY state.

## Operation
State machine with two states, IDLE and BUSY. Internal state is a 3-bit priority pointer `ptr` and a timeout counter `cnt`.

- **Reset values:** state=IDLE, ptr=0, cnt=0, sel=0, gnt=0, start=0, err=0, busy=0. These take effect immediately on rst assertion, including mid-transaction.
- **IDLE with req==0:** stay in IDLE. sel holds its last value. gnt=0.
- **IDLE with req!=0:**
  - Pick winner w = the first set bit of req scanning ptr, ptr+1, … ptr+7, mod 8.
  - Next edge: state=BUSY, gnt=1<<w, sel=w, start=1, cnt=0.
- **BUSY:**
  - start=0 after its first cycle.
  - gnt and sel are held constant for the whole transaction.
  - cnt increments each cycle, saturating at timeout.
- **BUSY with resp=1:**
  - done[w] pulses in the same cycle.
  - Next edge: state=IDLE, gnt=0, ptr=w+1 (3-bit wrap: 7 -> 0).
- **BUSY with no resp and cnt==timeout-1 (timeout>0):**
  - Next edge: err=1 for one cycle, state=IDLE, gnt=0, ptr=w+1.
- **resp and timeout in the same cycle:** resp wins. done pulses and err stays 0.
- **Requester drops req[w] during BUSY:** ignored. The transaction continues until resp or timeout.
- **resp in IDLE:** ignored. done=0 because gnt=0.
- **Arbitration sampling:** changes on req during BUSY have no effect. req is sampled only in IDLE.
- **No fairness violation:** a requester held continuously high is granted within 8 grants.

## Timing
- **Grant latency:** req rises in cycle n while IDLE -> gnt, sel and start valid in cycle n+1.
- **Release:** resp in cycle m -> gnt=0 and IDLE in cycle m+1. If req is still pending, the next grant and start come in cycle m+2.
- **Minimum transaction length:** 1 cycle (resp in the same cycle as start). The minimum grant-to-grant period is therefore 2 cycles.
- **Timeout:** with start in cycle n and no resp, err is high in cycle n+timeout and gnt drops in the same cycle.
- **Output timing:**
  - sel and gnt are glitch-free registered outputs, safe to drive the mux select directly.
  - done is combinational from resp and gnt.
- **Async reset mid-BUSY:** outputs clear without a clock edge. After rst deasserts, the first arbitration uses ptr=0.

## Test plan
- **Single requester:** req=8'h08 from IDLE, resp 4 cycles after start -> next cycle gnt=8'h08, sel=3, start pulse. done=8'h08 with resp. gnt=0 the cycle after. ptr=4.
- **Full rotation:** req=8'hFF held, resp asserted on every start cycle -> grants in order sel=0,1,…,7,0, with a new start every 2 cycles.
- **Wrap priority:** after granting requester 0, req=8'h81 -> grants 7 before 0. With ptr=7 and req=8'h03 -> grants 0 then 1.
- **Timeout:** timeout=8, req=8'h20, resp never asserted -> err pulse 8 cycles after start, gnt=0 that cycle, ptr=6. Repeat with resp in the same cycle as timeout -> done=8'h20 and err=0.
- **Async reset mid-transaction:** rst asserted 2 cycles into BUSY with gnt=8'h10 -> gnt, sel, busy and start all 0 before the next clock edge. After release with req=8'h11 -> grant goes to requester 0 first.
- **Spurious and dropped signals:** resp pulsed while IDLE -> no done and no state change. req[w] dropped during BUSY -> gnt held until resp.
